// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the multi-cycle data-memory stage.
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // Loads and stores decode funct3 differently: unknown store codes fall back to sw.
  function automatic size_t access_size(input logic is_store, input logic [2:0] f3);
    size_t sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side request bus and load/stall responses of the memory stage.
interface mem_stage_if;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [31:0] readdata;
  logic        rvalid;
  logic        stall;
  logic        misalign;

  modport master (
    output address, writedata, memread, memwrite, funct3,
    input  readdata, rvalid, stall, misalign
  );

  modport slave (
    input  address, writedata, memread, memwrite, funct3,
    output readdata, rvalid, stall, misalign
  );
endinterface

// File: rtl/mem_stage_align.sv
// Lane extract/extend for loads and byte/half merge for stores.
// MEM_STAGE_MISALIGN_EN enables detection of misaligned half/word accesses.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        misaligned
);

  size_t       size;
  logic        is_unsigned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size        = access_size(is_store, funct3);
    is_unsigned = (funct3 == F3_LBU) || (funct3 == F3_LHU);
    byte_sel    = mem_word[{byte_off, 3'b000} +: 8];
    half_sel    = mem_word[{byte_off[1], 4'b0000} +: 16];

    load_data  = mem_word;
    store_word = mem_word;
    case (size)
      SZ_BYTE: begin
        load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = mem_word;
        store_word = wdata;
      end
    endcase

`ifdef MEM_STAGE_MISALIGN_EN
    misaligned = ((size == SZ_HALF) && byte_off[0]) ||
                 ((size == SZ_WORD) && (byte_off != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle data-memory stage: wait-state FSM, stall generation and word storage.
// Optional MEM_STAGE_MISALIGN_EN turns misaligned half/word accesses into misalign pulses.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              store_q, store_d;
  logic              load_q, load_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              rvalid_q, rvalid_d;
  logic              misalign_q, misalign_d;

  logic              req, accept, complete, wr_en;
  logic [31:0]       cur_addr, cur_wdata;
  logic [2:0]        cur_f3;
  logic              cur_store, cur_load;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       words [DEPTH];
  logic [31:0]       rd_word, load_data, store_word;
  logic              misaligned;

  assign req    = bus.memread | bus.memwrite;
  assign accept = (state_q == IDLE) && req;

  // With zero wait states completion happens on the accept edge, so use live inputs then.
  assign cur_addr  = accept ? bus.address   : addr_q;
  assign cur_wdata = accept ? bus.writedata : wdata_q;
  assign cur_f3    = accept ? bus.funct3    : f3_q;
  assign cur_store = accept ? bus.memwrite  : store_q;
  assign cur_load  = accept ? (bus.memread & ~bus.memwrite) : load_q;
  assign idx       = IDX_W'(cur_addr[31:2] % 30'(DEPTH));
  assign rd_word   = words[idx];

  mem_stage_align u_align (
    .is_store   (cur_store),
    .funct3     (cur_f3),
    .byte_off   (cur_addr[1:0]),
    .mem_word   (rd_word),
    .wdata      (cur_wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    store_d    = store_q;
    load_d     = load_q;
    readdata_d = readdata_q;
    rvalid_d   = 1'b0;
    misalign_d = 1'b0;
    complete   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.address;
          wdata_d = bus.writedata;
          f3_d    = bus.funct3;
          store_d = bus.memwrite;
          load_d  = bus.memread & ~bus.memwrite;
          if (WAIT_CYCLES == 0) begin
            state_d  = DONE;
            complete = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (complete) begin
      if (misaligned) begin
        misalign_d = 1'b1;
      end else if (cur_load) begin
        readdata_d = load_data;
        rvalid_d   = 1'b1;
      end
    end
  end

  assign wr_en = complete & cur_store & ~misaligned;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      store_q    <= 1'b0;
      load_q     <= 1'b0;
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      store_q    <= store_d;
      load_q     <= load_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage powers up as word i = i and is deliberately untouched by reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [31:0] word_q = 32'(gi);
    always_ff @(posedge clk) begin
      if (rst && wr_en && (idx == IDX_W'(gi))) begin
        word_q <= store_word;
      end
    end
    assign words[gi] = word_q;
  end

  assign bus.readdata = readdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.misalign = misalign_q;
  assign bus.stall    = accept || (state_q == BUSY);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed scenarios plus random traffic
// checked against a byte-level memory model.
module tb_mem_stage_ctrl;

  localparam int DEPTH       = 128;
  localparam int WAIT_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          mis;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_load = 32'h0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Access width in bytes from funct3.
  function automatic int unsigned acc_bytes(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input int unsigned nb, input logic [31:0] addr);
`ifdef MEM_STAGE_MISALIGN_EN
    return (nb == 2 && addr % 2 != 0) || (nb == 4 && addr % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned lane_off(input int unsigned nb, input logic [31:0] addr);
    if (nb == 1) return addr % 4;
    if (nb == 2) return ((addr % 4) / 2) * 2;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] w, v, mask;
    int unsigned nb, off;
    w  = model_mem[(addr / 4) % DEPTH];
    nb = acc_bytes(1'b0, f3);
    if (nb == 4) return w;
    off  = lane_off(nb, addr);
    mask = (32'h1 << (8 * nb)) - 1;
    v    = (w >> (8 * off)) & mask;
    if (f3 < 3'd4 && v >= (32'h1 << (8 * nb - 1))) v = v | ~mask;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] w, mask;
    int unsigned nb, off, i;
    i  = (addr / 4) % DEPTH;
    nb = acc_bytes(1'b1, f3);
    if (nb == 4) begin
      model_mem[i] = wd;
    end else begin
      off  = lane_off(nb, addr);
      mask = ((32'h1 << (8 * nb)) - 1) << (8 * off);
      w    = model_mem[i];
      model_mem[i] = (w & ~mask) | ((wd << (8 * off)) & mask);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input string name);
    exp_t e;
    int   n;
    bit   mis;
    mis = is_mis(acc_bytes(wr, f3), addr);
    if (mis) begin
      e.mis = 1'b1; e.val = 32'h0; e.name = name; exp_q.push_back(e);
    end else if (rd && !wr) begin
      e.mis = 1'b0; e.val = model_load(f3, addr); e.name = name; exp_q.push_back(e);
    end else if (wr) begin
      model_store(f3, addr, wd);
    end
    @(posedge clk);
    #1;
    bus.memread = rd; bus.memwrite = wr; bus.funct3 = f3;
    bus.address = addr; bus.writedata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
      if (n > 40) begin
        checks++; failures++;
        $display("FAIL %s_timeout: stall stuck high for %0d cycles, required %0d", name, n, WAIT_CYCLES + 1);
        break;
      end
    end
    check({name, "_stall_len"}, 32'(n), 32'(WAIT_CYCLES + 1));
    $display("txn %s rd=%0d wr=%0d f3=%0d addr=0x%08h wdata=0x%08h stall_cycles=%0d",
             name, rd, wr, f3, addr, wd, n);
    @(posedge clk);
    #1;
    bus.memread = 1'b0; bus.memwrite = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every response pulse; readdata must hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_load = 32'h0;
    end else if (mon_en) begin
      if (bus.rvalid || bus.misalign) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_response: rvalid=%0d misalign=%0d readdata=0x%08h, required no response",
                   bus.rvalid, bus.misalign, bus.readdata);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_misalign"}, 32'(bus.misalign), 32'(e.mis));
          if (e.mis) begin
            check({e.name, "_rvalid"}, 32'(bus.rvalid), 32'h0);
            check({e.name, "_rd_unchanged"}, bus.readdata, last_load);
          end else begin
            check({e.name, "_readdata"}, bus.readdata, e.val);
            last_load = e.val;
          end
          $display("rsp %s rvalid=%0d misalign=%0d readdata=0x%08h", e.name, bus.rvalid, bus.misalign, bus.readdata);
        end
      end else begin
        check("readdata_hold", bus.readdata, last_load);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(i);
    bus.memread = 1'b0; bus.memwrite = 1'b0; bus.funct3 = 3'd0;
    bus.address = 32'h0; bus.writedata = 32'h0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_rvalid", 32'(bus.rvalid), 32'h0);
    check("reset_misalign", 32'(bus.misalign), 32'h0);
    check("reset_stall", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;

    access(1, 0, 3'd2, 32'h10, 32'h0, "lw_0x10");
    access(0, 1, 3'd2, 32'h20, 32'hDEADBEEF, "sw_0x20");
    access(1, 0, 3'd4, 32'h21, 32'h0, "lbu_0x21");
    access(1, 0, 3'd0, 32'h23, 32'h0, "lb_0x23");
    access(1, 0, 3'd1, 32'h22, 32'h0, "lh_0x22");
    access(1, 0, 3'd5, 32'h22, 32'h0, "lhu_0x22");
    access(1, 0, 3'd2, 32'h42, 32'h0, "lw_0x42_misaligned");
    access(0, 1, 3'd0, 32'h41, 32'h7F, "sb_0x41");
    access(1, 0, 3'd2, 32'h40, 32'h0, "lw_0x40");
    access(1, 1, 3'd2, 32'h8, 32'h55, "rdwr_sw_0x8");
    access(1, 0, 3'd2, 32'h8, 32'h0, "lw_0x8");

    // Reset while the store is still waiting must discard it.
    @(posedge clk);
    #1;
    bus.memwrite = 1'b1; bus.funct3 = 3'd2; bus.address = 32'h30; bus.writedata = 32'h1234;
    @(negedge clk);
    @(negedge clk);
    check("abort_stall_busy", 32'(bus.stall), 32'h1);
    #1;
    rst = 1'b0; bus.memwrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_stall_after_reset", 32'(bus.stall), 32'h0);
    check("abort_readdata", bus.readdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    access(1, 0, 3'd2, 32'h30, 32'h0, "lw_0x30_after_abort");

    for (int t = 0; t < 80; t++) begin
      int unsigned kind;
      logic [31:0] a;
      kind = $urandom_range(0, 4);
      a    = 32'($urandom_range(0, 8 * DEPTH - 1));
      if (kind <= 2)
        access(1, 0, 3'($urandom_range(0, 7)), a, 32'h0, $sformatf("rnd%0d_load", t));
      else if (kind == 3)
        access(0, 1, 3'($urandom_range(0, 7)), a, $urandom, $sformatf("rnd%0d_store", t));
      else
        access(1, 1, 3'($urandom_range(0, 7)), a, $urandom, $sformatf("rnd%0d_rdwr", t));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
